// File: rtl/poly_osc_mixer_pkg.sv
// Shared encodings for the polyphonic oscillator mixer: waveform codes, FSM states, default rate.
package poly_osc_mixer_pkg;

    localparam logic [1:0] WAVE_SAW    = 2'd0;
    localparam logic [1:0] WAVE_SQUARE = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;
    localparam logic [1:0] WAVE_OFF    = 2'd3;

    // 25 MHz / 520 is close to 48 kHz
    localparam int SAMPLE_DIV_48K = 520;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/poly_osc_mixer_if.sv
// Voice configuration write port and mixed sample output of the oscillator bank.
// Fire-and-forget: config writes are always accepted, samples cannot be stalled.
interface poly_osc_mixer_if #(
    parameter int VW      = 2,
    parameter int PHASE_W = 24,
    parameter int OUT_W   = 16
);
    logic                    cfg_we;
    logic [VW-1:0]           cfg_voice;
    logic [PHASE_W-1:0]      cfg_tuning;
    logic [1:0]              cfg_wave;
    logic                    cfg_gate;
    logic signed [OUT_W-1:0] sample_out;
    logic                    sample_valid;
    logic                    busy;

    modport master (
        output cfg_we, cfg_voice, cfg_tuning, cfg_wave, cfg_gate,
        input  sample_out, sample_valid, busy
    );

    modport slave (
        input  cfg_we, cfg_voice, cfg_tuning, cfg_wave, cfg_gate,
        output sample_out, sample_valid, busy
    );
endinterface

// File: rtl/poly_osc_mixer_wave_shaper.sv
// Pipeline stage 1: maps a voice's top phase bits to a signed saw/square/triangle sample.
// Latency 1 clock, no backpressure; a gated-off voice yields 0.
module osc_wave_shaper
    import poly_osc_mixer_pkg::*;
#(
    parameter int PCM_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PCM_W-1:0]        u,
    input  logic [1:0]              wave,
    input  logic                    gate,
    output logic signed [PCM_W-1:0] pcm_q
);

    logic [PCM_W-1:0]        tri_t;
    logic signed [PCM_W-1:0] pcm_d;

    always_comb begin
        tri_t = {u[PCM_W-2:0], 1'b0};
        if (u[PCM_W-1]) begin
            tri_t = ~tri_t;
        end

        pcm_d = '0;
        // Subtracting H from an unsigned PCM_W value is the same as flipping its MSB
        case (wave)
            WAVE_SAW:    pcm_d = {~u[PCM_W-1], u[PCM_W-2:0]};
            WAVE_SQUARE: pcm_d = u[PCM_W-1] ? {1'b1, {(PCM_W-1){1'b0}}}
                                            : {1'b0, {(PCM_W-1){1'b1}}};
            WAVE_TRI:    pcm_d = {~tri_t[PCM_W-1], tri_t[PCM_W-2:0]};
            default:     pcm_d = '0;
        endcase
        if (!gate) begin
            pcm_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcm_q <= '0;
        end else begin
            pcm_q <= pcm_d;
        end
    end

endmodule

// File: rtl/poly_osc_mixer.sv
// Multi-voice phase-accumulator oscillator bank, voices scanned through one shaper and summed.
// One sample per SAMPLE_DIV clocks, valid NUM_VOICES+3 clocks after the divider tick; no backpressure.
module poly_osc_mixer
    import poly_osc_mixer_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 24,
    parameter int PCM_W      = 12,
    parameter int OUT_W      = 16,
    parameter int SAMPLE_DIV = SAMPLE_DIV_48K
) (
    input  logic             clk,
    input  logic             rst,
    poly_osc_mixer_if.slave  bus
);

    localparam int VW    = $clog2(NUM_VOICES);
    localparam int ACC_W = PCM_W + VW;
    localparam int SHIFT = OUT_W - ACC_W;
    localparam int CNT_W = $clog2(SAMPLE_DIV);

    logic [PHASE_W-1:0] tun_q   [NUM_VOICES];
    logic [PHASE_W-1:0] tun_d   [NUM_VOICES];
    logic [PHASE_W-1:0] phase_q [NUM_VOICES];
    logic [PHASE_W-1:0] phase_d [NUM_VOICES];
    logic [1:0]         wave_q  [NUM_VOICES];
    logic [1:0]         wave_d  [NUM_VOICES];
    logic               gate_q  [NUM_VOICES];
    logic               gate_d  [NUM_VOICES];

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    state_e                  state_q, state_d;
    logic [VW-1:0]           vidx_q, vidx_d;
    logic                    drain_cnt_q, drain_cnt_d;
    logic                    s1_vld_q, s1_vld_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [OUT_W-1:0] sample_out_q, sample_out_d;

    logic                    tick;
    logic                    scan;
    logic [PCM_W-1:0]        cur_u;
    logic signed [PCM_W-1:0] s1_pcm;

    assign tick  = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
    assign scan  = (state_q == ST_SCAN);
    assign cur_u = phase_q[vidx_q][PHASE_W-1 -: PCM_W];

    osc_wave_shaper #(
        .PCM_W (PCM_W)
    ) u_shaper (
        .clk   (clk),
        .rst   (rst),
        .u     (cur_u),
        .wave  (wave_q[vidx_q]),
        .gate  (gate_q[vidx_q]),
        .pcm_q (s1_pcm)
    );

    // Voice registers: the scanned voice reads current values, so a same-cycle write lands next sample
    always_comb begin
        tun_d   = tun_q;
        wave_d  = wave_q;
        gate_d  = gate_q;
        phase_d = phase_q;
        if (scan) begin
            phase_d[vidx_q] = gate_q[vidx_q] ? phase_q[vidx_q] + tun_q[vidx_q] : '0;
        end
        if (bus.cfg_we) begin
            tun_d[bus.cfg_voice]  = bus.cfg_tuning;
            wave_d[bus.cfg_voice] = bus.cfg_wave;
            gate_d[bus.cfg_voice] = bus.cfg_gate;
        end
    end

    always_comb begin
        cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
        state_d      = state_q;
        vidx_d       = vidx_q;
        drain_cnt_d  = drain_cnt_q;
        s1_vld_d     = scan;
        acc_d        = acc_q;
        sample_out_d = sample_out_q;

        if (s1_vld_q) begin
            acc_d = acc_q + ACC_W'(s1_pcm);
        end

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_SCAN;
                    vidx_d  = '0;
                    acc_d   = '0;
                end
            end
            ST_SCAN: begin
                vidx_d = vidx_q + VW'(1);
                if (vidx_q == VW'(NUM_VOICES - 1)) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                drain_cnt_d = 1'b1;
                // Last voice lands in the accumulator during the second drain cycle
                if (drain_cnt_q) begin
                    state_d      = ST_OUT;
                    sample_out_d = OUT_W'(acc_q) <<< SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                tun_q[i]   <= '0;
                phase_q[i] <= '0;
                wave_q[i]  <= '0;
                gate_q[i]  <= 1'b0;
            end
            cnt_q        <= '0;
            state_q      <= ST_IDLE;
            vidx_q       <= '0;
            drain_cnt_q  <= 1'b0;
            s1_vld_q     <= 1'b0;
            acc_q        <= '0;
            sample_out_q <= '0;
        end else begin
            tun_q        <= tun_d;
            phase_q      <= phase_d;
            wave_q       <= wave_d;
            gate_q       <= gate_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            vidx_q       <= vidx_d;
            drain_cnt_q  <= drain_cnt_d;
            s1_vld_q     <= s1_vld_d;
            acc_q        <= acc_d;
            sample_out_q <= sample_out_d;
        end
    end

    assign bus.sample_out   = sample_out_q;
    assign bus.sample_valid = (state_q == ST_OUT);
    assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_poly_osc_mixer.sv
// Scoreboard bench for poly_osc_mixer: a behavioural voice model predicts each sample at its tick.
module tb_poly_osc_mixer;
    import poly_osc_mixer_pkg::*;

    localparam int NV  = 4;
    localparam int VW  = 2;
    localparam int PW  = 24;
    localparam int PCM = 12;
    localparam int OW  = 16;
    localparam int DIV = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    poly_osc_mixer_if #(.VW(VW), .PHASE_W(PW), .OUT_W(OW)) bus ();

    poly_osc_mixer #(
        .NUM_VOICES (NV),
        .PHASE_W    (PW),
        .PCM_W      (PCM),
        .OUT_W      (OW),
        .SAMPLE_DIV (DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    int n_vec = 0;
    int n_bad = 0;
    int exp_q[$];
    int last_out = 0;
    bit mon_en = 1'b0;

    int m_tun[NV];
    int m_wave[NV];
    int m_phase[NV];
    bit m_gate[NV];

    task automatic check_eq(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cyc %0d: got %0d expected %0d", tag, cyc, act, exp);
        end
    endtask

    function automatic int shape(input int u, input int w);
        int t;
        case (w)
            0: return u - 2048;
            1: return (u < 2048) ? 2047 : -2048;
            2: begin
                t = (u * 2) % 4096;
                if (u >= 2048) t = 4095 - t;
                return t - 2048;
            end
            default: return 0;
        endcase
    endfunction

    task automatic model_push();
        int sum = 0;
        for (int v = 0; v < NV; v++) begin
            if (m_gate[v]) begin
                sum += shape(m_phase[v] >> 12, m_wave[v]);
                m_phase[v] = (m_phase[v] + m_tun[v]) & 'hFFFFFF;
            end else begin
                m_phase[v] = 0;
            end
        end
        exp_q.push_back(sum * 4);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (!rst && (cyc % DIV) == DIV - 1) model_push();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic goto_phase(input int p);
        do step(); while ((cyc % DIV) != p);
    endtask

    task automatic cfg_write(input int v, input int w, input int tun, input bit g);
        logic [31:0] tv;
        tv             = tun;
        bus.cfg_we     = 1'b1;
        bus.cfg_voice  = VW'(v);
        bus.cfg_tuning = tv[PW-1:0];
        bus.cfg_wave   = 2'(w);
        bus.cfg_gate   = g;
        m_tun[v]  = tun & 'hFFFFFF;
        m_wave[v] = w;
        m_gate[v] = g;
        step();
        bus.cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int v = 0; v < NV; v++) begin
            m_tun[v] = 0; m_wave[v] = 0; m_phase[v] = 0; m_gate[v] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_eq("rst_sample_out", bus.sample_out, 0);
        check_eq("rst_valid", bus.sample_valid, 0);
        check_eq("rst_busy", bus.busy, 0);
    endtask

    int p;
    int exp_v;
    int exp_b;
    int popped;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            last_out = 0;
        end else if (mon_en) begin
            p     = cyc % DIV;
            exp_v = (cyc >= DIV + 6 && p == 6) ? 1 : 0;
            exp_b = (cyc >= DIV && p <= 6) ? 1 : 0;
            check_eq("sample_valid", bus.sample_valid, exp_v);
            check_eq("busy", bus.busy, exp_b);
            if (bus.sample_valid) begin
                check_eq("sb_pending", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    popped = exp_q.pop_front();
                    check_eq("sample_out", bus.sample_out, popped);
                    last_out = popped;
                end
            end else begin
                check_eq("sample_hold", bus.sample_out, last_out);
            end
        end
    end

    initial begin
        bus.cfg_we = 1'b0; bus.cfg_voice = '0; bus.cfg_tuning = '0;
        bus.cfg_wave = '0; bus.cfg_gate = 1'b0;

        // Idle bank after reset: silent samples on the fixed cadence
        do_reset();
        mon_en = 1'b1;
        run(3 * DIV + 8);

        // Saw sweep on voice 0
        goto_phase(8); cfg_write(0, WAVE_SAW, 'h100000, 1'b1);
        run(17 * DIV);

        // Square, restarted from phase 0 by one gated-off sample
        goto_phase(8); cfg_write(0, WAVE_SQUARE, 'h800000, 1'b0);
        goto_phase(8); cfg_write(0, WAVE_SQUARE, 'h800000, 1'b1);
        run(4 * DIV);

        // Triangle from phase 0
        goto_phase(8); cfg_write(0, WAVE_TRI, 'h400000, 1'b0);
        goto_phase(8); cfg_write(0, WAVE_TRI, 'h400000, 1'b1);
        run(5 * DIV);

        // Full-scale mix of four squares, then drop and re-gate voice 3
        do_reset();
        goto_phase(8);
        for (int v = 0; v < NV; v++) cfg_write(v, WAVE_SQUARE, 0, 1'b1);
        run(3 * DIV);
        goto_phase(8); cfg_write(3, WAVE_SQUARE, 0, 1'b0);
        run(3 * DIV);
        goto_phase(8); cfg_write(3, WAVE_SQUARE, 0, 1'b1);
        run(3 * DIV);

        // Random voice configs, including back-to-back writes to one voice
        for (int k = 0; k < 6; k++) begin
            goto_phase(8);
            for (int v = 0; v < NV; v++)
                cfg_write(v, $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
            cfg_write(1, $urandom_range(0, 3), $urandom, 1'b0);
            cfg_write(1, $urandom_range(0, 2), $urandom, 1'b1);
            run(3 * DIV);
        end

        // Write voice 2 during its own scan cycle (T+3): old config for that sample
        goto_phase(8); cfg_write(2, WAVE_SQUARE, 0, 1'b1);
        goto_phase(2); cfg_write(2, WAVE_SAW, 'h800000, 1'b1);
        run(3 * DIV);

        // Reset at T+2 aborts the sample in flight
        goto_phase(1);
        do_reset();
        run(2 * DIV);
        goto_phase(8);
        check_eq("sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
